// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and state type for the CPU control-step logic.
package cpu_ctrl_pkg;
    localparam int unsigned STEP_W    = 5;
    localparam int unsigned MAX_STEPS = 10;
    localparam int unsigned ONEHOT_W  = 20;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/step_decoder.sv
// Step code to one-hot timing strobe: step k (1..MAX_STEPS) sets bit k-1, anything else gives zero.
module step_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0]   step,
    output logic [ONEHOT_W-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int unsigned k = 1; k <= MAX_STEPS; k++) begin
            if (step == STEP_W'(k)) onehot[k-1] = 1'b1;
        end
    end
endmodule

// File: rtl/step_sequencer.sv
// Multicycle control-step sequencer: walks step 1..last_step with stall/clear, then pulses done.
// Optional saturating stall counter on stall_cycles when STEP_SEQ_STALL_CNT_EN is defined.
module step_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [STEP_W-1:0]   last_step,
    input  logic                stall,
    input  logic                clear,
    output logic [STEP_W-1:0]   step,
    output logic [ONEHOT_W-1:0] step_onehot,
    output logic                busy,
    output logic                done,
    output logic                error
`ifdef STEP_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);
    state_t            state;
    logic [STEP_W-1:0] last_r;
    logic              legal;

    assign legal = (last_step != '0) && (last_step <= STEP_W'(MAX_STEPS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            step   <= '0;
            last_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && legal) begin
                        last_r <= last_step;
                        step   <= STEP_W'(1);
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else begin
                        error <= start;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (clear || (!stall && step == last_r)) begin
                        state <= DONE;
                        step  <= '0;
                        done  <= 1'b1;
                    end else if (!stall) begin
                        step <= step + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    step  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == RUN && stall && !clear && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    step_decoder u_dec (
        .step   (step),
        .onehot (step_onehot)
    );
endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer: per-instruction traces expanded from a transaction-level model.
module tb_step_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  last_step = '0;
    logic        stall = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  step;
    logic [19:0] step_onehot;
    logic        busy, done, error;
`ifdef STEP_SEQ_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int exp_stalls = 0;

    always #5 clk = ~clk;

    step_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .last_step   (last_step),
        .stall       (stall),
        .clear       (clear),
        .step        (step),
        .step_onehot (step_onehot),
        .busy        (busy),
        .done        (done),
        .error       (error)
`ifdef STEP_SEQ_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // One entry per clock cycle: inputs driven in that cycle and outputs expected in it.
    typedef struct {
        logic       rst, st;
        logic [4:0] ls;
        logic       stl, clr;
        logic [4:0] e_step;
        logic       e_busy, e_done, e_err;
    } ent_t;

    ent_t        tr[$];
    logic [27:0] obs[$];

    function automatic logic [19:0] onehot_of(input logic [4:0] k);
        onehot_of = (k >= 1 && k <= 10) ? (20'd1 << (k - 1)) : 20'd0;
    endfunction

    function automatic logic [27:0] expv(input ent_t e);
        expv = {e.e_step, onehot_of(e.e_step), e.e_busy, e.e_done, e.e_err};
    endfunction

    task automatic push(input logic rst, input logic st, input logic [4:0] ls, input logic stl,
                        input logic clr, input logic [4:0] s, input logic b, input logic d,
                        input logic er);
        ent_t e;
        e.rst = rst; e.st = st; e.ls = ls; e.stl = stl; e.clr = clr;
        e.e_step = s; e.e_busy = b; e.e_done = d; e.e_err = er;
        tr.push_back(e);
    endtask

    // Idle cycle: stall/clear are noise and must be ignored.
    task automatic add_idle();
        push(0, 0, 5'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
    endtask

    task automatic add_reject(input logic [4:0] ls);
        push(0, 1, ls, 1'($urandom), 1'($urandom), 0, 0, 0, 0);
        push(0, 0, 5'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 1);
    endtask

    task automatic add_instr(input int n, input int stall_pct, input int stall_at,
                             input int stall_len, input int clear_at, input int reset_at,
                             input bit b2b);
        int nst;
        if (b2b && tr.size() > 0 && tr[tr.size()-1].e_done) begin
            ent_t e;
            e = tr[tr.size()-1];
            e.st = 1'b1;
            e.ls = 5'(n);
            tr[tr.size()-1] = e;
        end else begin
            push(0, 1, 5'(n), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
        end
        for (int k = 1; k <= n; k++) begin
            nst = (k == stall_at) ? stall_len : 0;
            while (nst < 3 && int'($urandom_range(99)) < stall_pct) nst++;
            for (int j = 0; j < nst; j++) begin
                push(0, 1'($urandom), 5'($urandom), 1, 0, 5'(k), 1, 0, 0);
                exp_stalls++;
            end
            if (k == reset_at) begin
                push(1, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'(k), 1, 0, 0);
                exp_stalls = 0;
                add_idle();
                return;
            end
            if (k == clear_at) begin
                push(0, 1'($urandom), 5'($urandom), 1'($urandom), 1, 5'(k), 1, 0, 0);
                break;
            end
            push(0, 1'($urandom), 5'($urandom), 0, 0, 5'(k), 1, 0, 0);
        end
        push(0, 0, 5'($urandom), 1'($urandom), 1'($urandom), 0, 1, 1, 0);
    endtask

    task automatic play();
        obs.delete();
        foreach (tr[i]) begin
            reset = tr[i].rst; start = tr[i].st; last_step = tr[i].ls;
            stall = tr[i].stl; clear = tr[i].clr;
            obs.push_back({step, step_onehot, busy, done, error});
            @(posedge clk); #1;
        end
        reset = 0; start = 0; stall = 0; clear = 0;
    endtask

    task automatic test_reset();
        reset = 1; start = 1; last_step = 5'd3; stall = 1; clear = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if ({step, step_onehot, busy, done, error} !== 28'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", i,
                         {step, step_onehot, busy, done, error});
            end
        end
        reset = 0; start = 0; stall = 0;
        @(posedge clk); #1;
        total++;
        if ({step, step_onehot, busy, done, error} !== 28'd0) begin
            bad++;
            $display("FAIL reset_release got=%h want=0", {step, step_onehot, busy, done, error});
        end
        exp_stalls = 0;
`ifdef STEP_SEQ_STALL_CNT_EN
        total++;
        if (stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_stallcnt got=%0d want=0", stall_cycles);
        end
`endif
    endtask

    task automatic test_basic();
        tr.delete();
        add_instr(3, 0, 0, 0, 0, 0, 0);
        add_idle();
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== expv(tr[i])) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%h want=%h", i, obs[i], expv(tr[i]));
            end
        end
    endtask

    task automatic test_stall();
        tr.delete();
        add_instr(5, 0, 2, 2, 0, 0, 0);
        add_idle();
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== expv(tr[i])) begin
                bad++;
                $display("FAIL stall cyc=%0d got=%h want=%h", i, obs[i], expv(tr[i]));
            end
        end
`ifdef STEP_SEQ_STALL_CNT_EN
        total++;
        if (stall_cycles !== 16'(exp_stalls) || exp_stalls != 2) begin
            bad++;
            $display("FAIL stall_count got=%0d want=2", stall_cycles);
        end
`endif
    endtask

    task automatic test_clear();
        tr.delete();
        add_instr(5, 0, 0, 0, 2, 0, 0);
        add_idle();
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== expv(tr[i])) begin
                bad++;
                $display("FAIL clear cyc=%0d got=%h want=%h", i, obs[i], expv(tr[i]));
            end
        end
    endtask

    task automatic test_reject();
        tr.delete();
        add_reject(5'd0);
        add_reject(5'd11);
        add_reject(5'd31);
        add_idle();
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== expv(tr[i])) begin
                bad++;
                $display("FAIL reject cyc=%0d got=%h want=%h", i, obs[i], expv(tr[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        tr.delete();
        add_instr(4, 0, 0, 0, 0, 0, 0);
        add_instr(10, 0, 0, 0, 0, 0, 1);
        add_instr(1, 0, 0, 0, 0, 0, 1);
        add_instr(6, 0, 0, 0, 0, 4, 1);
        add_idle();
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== expv(tr[i])) begin
                bad++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs[i], expv(tr[i]));
            end
        end
    endtask

    task automatic test_random();
        int n;
        tr.delete();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(9) == 0) begin
                if ($urandom_range(1) == 0) add_reject(5'd0);
                else add_reject(5'($urandom_range(31, 11)));
            end
            n = int'($urandom_range(10, 1));
            add_instr(n, 25, 0, 0,
                      ($urandom_range(3) == 0) ? int'($urandom_range(n, 1)) : 0,
                      0, bit'($urandom_range(1)));
            if ($urandom_range(2) == 0) add_idle();
        end
        add_idle();
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== expv(tr[i])) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs[i], expv(tr[i]));
            end
        end
`ifdef STEP_SEQ_STALL_CNT_EN
        total++;
        if (stall_cycles !== 16'(exp_stalls)) begin
            bad++;
            $display("FAIL random_stall_count got=%0d want=%0d", stall_cycles, exp_stalls);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_clear();
        test_reject();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
